hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
- Pipeline stall/flush controller for the 5-stage core (IF, ID, EX, MEM, WB). It sits beside the operand forwarding unit and covers the hazards forwarding cannot resolve.
- It handles three cases: load-use (an EX/MEM load result is not forwardable), data-memory wait (MEM handshake not complete), and control redirect (branch or jump resolved in EX).
- It drives per-stage stall, bubble and flush strobes and keeps a saturating stall-cycle counter.

Parameters:
- FLUSH_CYCLES, 2: total cycles flushFetchDecode stays asserted per redirect. Must be ≥1. Covers the instruction-fetch latency.
- COUNT_WIDTH, 16: width of stallCycleCount.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- decodeExecuteRegister1  in  5  rs1 of the instruction in the ID/EX register.
- decodeExecuteRegister2  in  5  rs2 of the instruction in the ID/EX register.
- decodeExecuteUses1  in  1  ID/EX instruction reads rs1.
- decodeExecuteUses2  in  1  ID/EX instruction reads rs2.
- decodeExecuteValid  in  1  ID/EX holds a live instruction.
- executeMemoryDestinationRegister  in  5  rd in the EX/MEM register.
- executeMemoryValid  in  1  EX/MEM holds a live instruction.
- executeMemoryIsLoad  in  1  EX/MEM instruction writes back loaded data.
- memoryRequest  in  1  MEM stage has an outstanding data-memory access.
- memoryReady  in  1  data memory completes the access this cycle.
- redirectValid  in  1  EX resolved a taken branch or jump this cycle.
- stallFetch  out  1  hold the PC and the IF/ID register.
- stallDecode  out  1  hold the ID/EX register.
- stallMemory  out  1  hold the EX/MEM and MEM/WB registers.
- bubbleExecuteMemory  out  1  load a bubble (valid=0) into EX/MEM.
- flushFetchDecode  out  1  invalidate the IF/ID register.
- flushDecodeExecute  out  1  invalidate the ID/EX register.
- hazardState  out  2  current FSM state.
- stallCycleCount  out  COUNT_WIDTH  cycles in which stallFetch=1, saturating.

Behaviour:
- FSM states: RUN=0, MEM_WAIT=1, FLUSH=2. Encoding 3 is illegal and returns to RUN next cycle. All outputs are combinational from state and inputs.
- Reset (synchronous, active-high):
  - state=RUN, stallCycleCount=0, flush down-counter=0.
  - While reset=1, all strobes read 0 and hazardState=0.
- Condition definitions:
  - memWait = memoryRequest & ~memoryReady.
  - loadUse = decodeExecuteValid & executeMemoryValid & executeMemoryIsLoad & (executeMemoryDestinationRegister != 0) & ((decodeExecuteUses1 & rs1 == rd) | (decodeExecuteUses2 & rs2 == rd)).
- Per-cycle priority, evaluated in any state: memWait > loadUse > redirectValid.
- memWait:
  - Asserts stallFetch, stallDecode and stallMemory. No bubbles, no flushes.
  - The next state is MEM_WAIT while memWait holds.
  - redirectValid is ignored under memWait; EX is frozen, so the redirect stays presented until it can be taken.
- loadUse (no memWait):
  - Asserts stallFetch, stallDecode and bubbleExecuteMemory for exactly that cycle.
  - The load advances to MEM/WB and is then forwarded from there.
  - A redirect presented in the same cycle is ignored, because the branch's operands are stale.
  - No state change.
- redirectValid (no memWait, no loadUse):
  - Asserts flushFetchDecode and flushDecodeExecute that cycle.
  - If FLUSH_CYCLES>1: next state=FLUSH and the down-counter loads FLUSH_CYCLES-1.
- MEM_WAIT: returns to RUN in the first cycle memWait=0. That cycle is evaluated under the RUN rules.
- FLUSH:
  - Asserts flushFetchDecode only; fetch is not stalled.
  - The counter decrements each non-memWait cycle; the state goes to RUN when it reaches 0.
  - A new redirectValid in FLUSH reloads the counter to FLUSH_CYCLES-1 and also asserts flushDecodeExecute.
  - memWait in FLUSH freezes the counter. Stall strobes follow the memWait rule and flushFetchDecode stays asserted.
- stallCycleCount: +1 on every cycle with stallFetch=1. It saturates at 2^COUNT_WIDTH-1 with no wrap.
- Register x0 never causes a load-use stall.

Test Plan:
- Load x5, then "add x6,x5,x1" in ID/EX (rs1=5, uses1=1) → stallFetch=stallDecode=bubbleExecuteMemory=1 for 1 cycle, then all 0. stallCycleCount=1.
- Load x0 with a consumer of x0, or a consumer with uses1=uses2=0 → no stall, all strobes 0.
- memoryRequest=1 with memoryReady low for 3 cycles → stallFetch/stallDecode/stallMemory=1 for 3 cycles and hazardState=1. RUN on the ready cycle. stallCycleCount=3.
- redirectValid=1 with FLUSH_CYCLES=2 → both flushes that cycle; flushFetchDecode only on the next cycle with hazardState=2; then RUN.
- redirectValid and loadUse in the same cycle → load-use stall only, no flush. Redirect honoured the following cycle.
- memWait and redirect asserted together for 2 cycles, then ready → flushes occur only on the ready cycle. COUNT_WIDTH=2 with 5 stall cycles → stallCycleCount saturates at 3.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Stall/flush controller for a 5-stage pipeline: resolves load-use, data-memory
// wait and control-redirect hazards, and counts the cycles fetch is stalled.
module hazard_sequencer #(
  parameter int FLUSH_CYCLES = 2,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             decodeExecuteRegister1,
  input  logic [4:0]             decodeExecuteRegister2,
  input  logic                   decodeExecuteUses1,
  input  logic                   decodeExecuteUses2,
  input  logic                   decodeExecuteValid,
  input  logic [4:0]             executeMemoryDestinationRegister,
  input  logic                   executeMemoryValid,
  input  logic                   executeMemoryIsLoad,
  input  logic                   memoryRequest,
  input  logic                   memoryReady,
  input  logic                   redirectValid,
  output logic                   stallFetch,
  output logic                   stallDecode,
  output logic                   stallMemory,
  output logic                   bubbleExecuteMemory,
  output logic                   flushFetchDecode,
  output logic                   flushDecodeExecute,
  output logic [1:0]             hazardState,
  output logic [COUNT_WIDTH-1:0] stallCycleCount
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;

  state_t                   state_reg, state_next;
  logic [FCW-1:0]           flush_cnt_reg, flush_cnt_next;
  logic [COUNT_WIDTH-1:0]   count_reg;

  logic mem_wait;
  logic load_use;
  logic match1, match2;

  assign mem_wait = memoryRequest & ~memoryReady;
  assign match1   = decodeExecuteUses1 & (decodeExecuteRegister1 == executeMemoryDestinationRegister);
  assign match2   = decodeExecuteUses2 & (decodeExecuteRegister2 == executeMemoryDestinationRegister);
  assign load_use = decodeExecuteValid & executeMemoryValid & executeMemoryIsLoad &
                    (executeMemoryDestinationRegister != 5'd0) & (match1 | match2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= RUN;
      flush_cnt_reg <= '0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      if (stallFetch && (count_reg != {COUNT_WIDTH{1'b1}}))
        count_reg <= count_reg + 1'b1;
    end
  end

  always_comb begin
    state_next          = state_reg;
    flush_cnt_next      = flush_cnt_reg;
    stallFetch          = 1'b0;
    stallDecode         = 1'b0;
    stallMemory         = 1'b0;
    bubbleExecuteMemory = 1'b0;
    flushFetchDecode    = 1'b0;
    flushDecodeExecute  = 1'b0;

    if (state_reg == ILLEGAL) begin
      state_next = RUN;
    end else if (mem_wait) begin
      // EX is frozen, so any pending redirect stays presented until memory completes
      stallFetch  = 1'b1;
      stallDecode = 1'b1;
      stallMemory = 1'b1;
      if (state_reg == FLUSH)
        flushFetchDecode = 1'b1;
      else
        state_next = MEM_WAIT;
    end else begin
      if (state_reg == FLUSH) begin
        flushFetchDecode = 1'b1;
        flush_cnt_next   = flush_cnt_reg - 1'b1;
        if (flush_cnt_reg <= FCW'(1))
          state_next = RUN;
      end else begin
        state_next = RUN;
      end

      // A redirect alongside a load-use is dropped: the branch used stale operands
      if (load_use) begin
        stallFetch          = 1'b1;
        stallDecode         = 1'b1;
        bubbleExecuteMemory = 1'b1;
      end else if (redirectValid) begin
        flushFetchDecode   = 1'b1;
        flushDecodeExecute = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_next     = FLUSH;
          flush_cnt_next = FCW'(FLUSH_CYCLES - 1);
        end else begin
          state_next = RUN;
        end
      end
    end

    if (reset) begin
      stallFetch          = 1'b0;
      stallDecode         = 1'b0;
      stallMemory         = 1'b0;
      bubbleExecuteMemory = 1'b0;
      flushFetchDecode    = 1'b0;
      flushDecodeExecute  = 1'b0;
    end
  end

  assign hazardState     = reset ? 2'd0 : state_reg;
  assign stallCycleCount = count_reg;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed test of hazard_sequencer: load-use, memory wait, redirect/flush
// interactions and stall-counter saturation (second instance with COUNT_WIDTH=2).
module tb_hazard_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  de_rs1, de_rs2, em_rd;
  logic        de_u1, de_u2, de_valid, em_valid, em_load;
  logic        mem_req, mem_rdy, redirect;

  logic        sf, sd, sm, bub, ffd, fde;
  logic [1:0]  hs;
  logic [15:0] count;

  logic        s_sf, s_sd, s_sm, s_bub, s_ffd, s_fde;
  logic [1:0]  s_hs;
  logic [1:0]  s_count;

  logic [7:0]  strobes;
  assign strobes = {sf, sd, sm, bub, ffd, fde, hs};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.FLUSH_CYCLES(2), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .decodeExecuteRegister1(de_rs1), .decodeExecuteRegister2(de_rs2),
    .decodeExecuteUses1(de_u1), .decodeExecuteUses2(de_u2),
    .decodeExecuteValid(de_valid),
    .executeMemoryDestinationRegister(em_rd), .executeMemoryValid(em_valid),
    .executeMemoryIsLoad(em_load),
    .memoryRequest(mem_req), .memoryReady(mem_rdy), .redirectValid(redirect),
    .stallFetch(sf), .stallDecode(sd), .stallMemory(sm),
    .bubbleExecuteMemory(bub), .flushFetchDecode(ffd), .flushDecodeExecute(fde),
    .hazardState(hs), .stallCycleCount(count)
  );

  hazard_sequencer #(.FLUSH_CYCLES(2), .COUNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset),
    .decodeExecuteRegister1(de_rs1), .decodeExecuteRegister2(de_rs2),
    .decodeExecuteUses1(de_u1), .decodeExecuteUses2(de_u2),
    .decodeExecuteValid(de_valid),
    .executeMemoryDestinationRegister(em_rd), .executeMemoryValid(em_valid),
    .executeMemoryIsLoad(em_load),
    .memoryRequest(mem_req), .memoryReady(mem_rdy), .redirectValid(redirect),
    .stallFetch(s_sf), .stallDecode(s_sd), .stallMemory(s_sm),
    .bubbleExecuteMemory(s_bub), .flushFetchDecode(s_ffd), .flushDecodeExecute(s_fde),
    .hazardState(s_hs), .stallCycleCount(s_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic dv, input logic [4:0] rd,
                        input logic ev, input logic ld, input logic mq,
                        input logic mr, input logic rv);
    de_rs1 = rs1; de_rs2 = rs2; de_u1 = u1; de_u2 = u2; de_valid = dv;
    em_rd = rd; em_valid = ev; em_load = ld;
    mem_req = mq; mem_rdy = mr; redirect = rv;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Strobes sampled mid-cycle as {sf,sd,sm,bubble,flushFD,flushDE,state[1:0]}
  task automatic step(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk(tag, {24'd0, strobes}, {24'd0, exp});
    $display("step %-14s strobes=%08b count=%0d", tag, strobes, count);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    step("reset_strobes", 8'b0000_0000);
    chk("reset_count", {16'd0, count}, 32'd0);
    chk("reset_sat_count", {30'd0, s_count}, 32'd0);
    idle();
    reset = 1'b0;

    // load-use via rs1
    set_in(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rs1", 8'b1101_0000);
    idle();
    step("lu_after", 8'b0000_0000);
    chk("lu_count", {16'd0, count}, 32'd1);

    // x0 destination, no-use consumer, mismatched register: no stall
    set_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_x0", 8'b0000_0000);
    set_in(5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_nouse", 8'b0000_0000);
    set_in(5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_nomatch", 8'b0000_0000);
    set_in(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_notload", 8'b0000_0000);
    // load-use via rs2 only
    set_in(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rs2", 8'b1101_0000);
    idle();
    chk("lu_count2", {16'd0, count}, 32'd2);

    // memory wait for 3 cycles
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("mw_1", 8'b1110_0000);
    step("mw_2", 8'b1110_0001);
    step("mw_3", 8'b1110_0001);
    mem_rdy = 1'b1;
    step("mw_ready", 8'b0000_0001);
    idle();
    step("mw_run", 8'b0000_0000);
    chk("mw_count", {16'd0, count}, 32'd5);

    // redirect with FLUSH_CYCLES=2
    redirect = 1'b1;
    step("rd_cycle", 8'b0000_1100);
    redirect = 1'b0;
    step("rd_flush", 8'b0000_1010);
    step("rd_run", 8'b0000_0000);
    chk("rd_count", {16'd0, count}, 32'd5);

    // redirect with load-use: stall wins, redirect taken next cycle
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("rdlu_stall", 8'b1101_0000);
    idle(); redirect = 1'b1;
    step("rdlu_redir", 8'b0000_1100);
    idle();
    step("rdlu_flush", 8'b0000_1010);
    step("rdlu_run", 8'b0000_0000);
    chk("rdlu_count", {16'd0, count}, 32'd6);

    // memory wait with redirect held for 2 cycles
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("mwrd_1", 8'b1110_0000);
    step("mwrd_2", 8'b1110_0001);
    mem_rdy = 1'b1;
    step("mwrd_ready", 8'b0000_1101);
    idle();
    step("mwrd_flush", 8'b0000_1010);
    step("mwrd_run", 8'b0000_0000);
    chk("mwrd_count", {16'd0, count}, 32'd8);

    // memory wait inside FLUSH freezes the counter
    redirect = 1'b1;
    step("fmw_redir", 8'b0000_1100);
    idle(); mem_req = 1'b1;
    step("fmw_wait1", 8'b1110_1010);
    step("fmw_wait2", 8'b1110_1010);
    mem_rdy = 1'b1;
    step("fmw_ready", 8'b0000_1010);
    idle();
    step("fmw_run", 8'b0000_0000);
    chk("fmw_count", {16'd0, count}, 32'd10);

    // new redirect during FLUSH reloads the counter
    redirect = 1'b1;
    step("rr_first", 8'b0000_1100);
    step("rr_second", 8'b0000_1110);
    redirect = 1'b0;
    step("rr_flush", 8'b0000_1010);
    step("rr_run", 8'b0000_0000);

    // saturation of the 2-bit counter over 5 stall cycles
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("sat_reset", {30'd0, s_count}, 32'd0);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("sat_1", 8'b1110_0000);
    step("sat_2", 8'b1110_0001);
    chk("sat_count2", {30'd0, s_count}, 32'd2);
    step("sat_3", 8'b1110_0001);
    step("sat_4", 8'b1110_0001);
    step("sat_5", 8'b1110_0001);
    chk("sat_count5", {30'd0, s_count}, 32'd3);
    chk("wide_count5", {16'd0, count}, 32'd5);
    idle();
    step("sat_idle", 8'b0000_0001);
    chk("sat_hold", {30'd0, s_count}, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
